// File: rtl/acc_res_normalizer_pkg.sv
// Shared constants and types for the fixed-point accumulator read-out path.
package fixp_acc_pkg;
  localparam int ACC_DEPTH     = 32;
  localparam int PRE_REG_WIDTH = 128;
  localparam int ACC_WIDTH     = 2 * PRE_REG_WIDTH;
  localparam int IDX_WIDTH     = 5;
  localparam int FRAC_BITS     = 128;
  localparam int FP32_BIAS     = 127;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } drain_state_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;
endpackage

// File: rtl/acc_res_normalizer_lzc.sv
// Combinational leading-zero counter built as a binary tree of 2:1 merges.
module fixp_lzc #(
  parameter int W   = 256,
  parameter int LZW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]   i_data,
  output logic [LZW-1:0] o_lz,
  output logic           o_zero
);
  localparam int P = 1 << LZW;

  logic [P-1:0]   w_pad;
  logic           w_z [LZW+1][P];
  logic [LZW-1:0] w_c [LZW+1][P];

  // Node n at each level covers a slice ordered MSB-first; the left child is the upper half.
  always_comb begin
    w_pad = '1;
    w_pad[P-1 -: W] = i_data;
    for (int l = 0; l <= LZW; l++) begin
      for (int n = 0; n < P; n++) begin
        w_z[l][n] = 1'b0;
        w_c[l][n] = '0;
      end
    end
    for (int n = 0; n < P; n++) begin
      w_z[0][n] = ~w_pad[P-1-n];
    end
    for (int l = 1; l <= LZW; l++) begin
      for (int n = 0; n < (P >> l); n++) begin
        w_z[l][n] = w_z[l-1][2*n] & w_z[l-1][2*n+1];
        w_c[l][n] = w_z[l-1][2*n] ? ((LZW'(1) << (l-1)) + w_c[l-1][2*n+1])
                                  : w_c[l-1][2*n];
      end
    end
  end

  assign o_lz   = w_c[LZW][0];
  assign o_zero = w_z[LZW][0];
endmodule

// File: rtl/acc_res_normalizer.sv
// Drains ACC_DEPTH accumulator results and converts each to fp32 (truncating)
// through a 3-stage stall-able pipeline.
module acc_res_normalizer
  import fixp_acc_pkg::*;
#(
  parameter int ACC_DEPTH = fixp_acc_pkg::ACC_DEPTH,
  parameter int ACC_WIDTH = fixp_acc_pkg::ACC_WIDTH,
  parameter int IDX_WIDTH = fixp_acc_pkg::IDX_WIDTH,
  parameter int FRAC_BITS = fixp_acc_pkg::FRAC_BITS
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           drain_valid,
  output logic                           drain_ready,
  output logic                           clr_valid,
  input  logic                           clr_ready,
  input  logic                           res_tvalid,
  output logic                           res_tready,
  input  logic [IDX_WIDTH+ACC_WIDTH-1:0] res_tdata,
  output logic                           fp_tvalid,
  input  logic                           fp_tready,
  output logic [IDX_WIDTH+32:0]          fp_tdata,
  output logic                           drain_done,
  output logic                           idx_err
);
  localparam int LZ_W    = $clog2(ACC_WIDTH);
  localparam int EXP_OFS = ACC_WIDTH - 1 - FRAC_BITS + FP32_BIAS;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(ACC_DEPTH - 1);

  // Underflow flushes to signed zero, overflow saturates to signed infinity.
  function automatic fp32_t pack_fp32(input logic sign, input logic zero,
                                      input logic signed [11:0] exp,
                                      input logic [22:0] frac);
    fp32_t f;
    f.sign = sign;
    f.exp  = '0;
    f.frac = '0;
    if (!zero && exp >= 12'sd255) begin
      f.exp = 8'hFF;
    end else if (!zero && exp > 12'sd0) begin
      f.exp  = exp[7:0];
      f.frac = frac;
    end
    return f;
  endfunction

  drain_state_t                r_state;
  logic [IDX_WIDTH-1:0]        r_cnt;
  logic                        r_idx_err;

  logic                        w_adv;
  logic                        w_res_hs;
  logic [IDX_WIDTH-1:0]        w_idx;
  logic signed [ACC_WIDTH-1:0] w_acc;
  logic [ACC_WIDTH-1:0]        w_mag;

  logic                        r_vld_p1, r_sign_p1, r_last_p1;
  logic [ACC_WIDTH-1:0]        r_mag_p1;
  logic [IDX_WIDTH-1:0]        r_idx_p1;
  logic [LZ_W-1:0]             w_lz_p1;
  logic                        w_zero_p1;

  logic                        r_vld_p2, r_sign_p2, r_last_p2, r_zero_p2;
  logic [ACC_WIDTH-1:0]        r_mag_p2;
  logic [LZ_W-1:0]             r_lz_p2;
  logic [IDX_WIDTH-1:0]        r_idx_p2;
  logic signed [11:0]          w_exp_p2;
  logic [22:0]                 w_frac_p2;

  logic                        r_vld_p3, r_last_p3;
  fp32_t                       r_fp_p3;
  logic [IDX_WIDTH-1:0]        r_idx_p3;

  assign w_adv      = ~r_vld_p3 | fp_tready;
  assign res_tready = (r_state == DRAIN) & w_adv;
  assign w_res_hs   = res_tvalid & res_tready;
  assign w_idx      = res_tdata[IDX_WIDTH+ACC_WIDTH-1 -: IDX_WIDTH];
  assign w_acc      = res_tdata[ACC_WIDTH-1:0];
  // -2^(W-1) wraps onto itself, which read as unsigned is the correct magnitude.
  assign w_mag      = w_acc[ACC_WIDTH-1] ? $unsigned(-w_acc) : $unsigned(w_acc);

  assign drain_ready = (r_state == IDLE);
  assign clr_valid   = (r_state == CLR);
  assign fp_tvalid   = r_vld_p3;
  assign fp_tdata    = {r_last_p3, r_idx_p3, r_fp_p3};
  assign drain_done  = (r_state == FLUSH) & r_vld_p3 & fp_tready & r_last_p3;
  assign idx_err     = r_idx_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx_err <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_vld_p3  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (drain_valid) begin
          r_state   <= CLR;
          r_cnt     <= '0;
          r_idx_err <= 1'b0;
        end
        CLR:     if (clr_ready) r_state <= DRAIN;
        DRAIN:   if (w_res_hs && r_cnt == LAST_IDX) r_state <= FLUSH;
        FLUSH:   if (drain_done) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_res_hs) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_idx != r_cnt) r_idx_err <= 1'b1;
      end
      if (w_adv) begin
        r_vld_p1 <= w_res_hs;
        r_vld_p2 <= r_vld_p1;
        r_vld_p3 <= r_vld_p2;
      end
    end
  end

  fixp_lzc #(.W(ACC_WIDTH), .LZW(LZ_W)) u_lzc (
    .i_data (r_mag_p1),
    .o_lz   (w_lz_p1),
    .o_zero (w_zero_p1)
  );

  assign w_exp_p2  = 12'(EXP_OFS) - 12'(r_lz_p2);
  assign w_frac_p2 = 23'((r_mag_p2 << r_lz_p2) >> (ACC_WIDTH - 24));

  always_ff @(posedge clk) begin
    if (w_adv) begin
      // S1: sign / magnitude split
      r_sign_p1 <= w_acc[ACC_WIDTH-1];
      r_mag_p1  <= w_mag;
      r_idx_p1  <= w_idx;
      r_last_p1 <= (r_cnt == LAST_IDX);
      // S2: leading-zero count
      r_sign_p2 <= r_sign_p1;
      r_mag_p2  <= r_mag_p1;
      r_lz_p2   <= w_lz_p1;
      r_zero_p2 <= w_zero_p1;
      r_idx_p2  <= r_idx_p1;
      r_last_p2 <= r_last_p1;
      // S3: normalise and pack
      r_fp_p3   <= pack_fp32(r_sign_p2, r_zero_p2, w_exp_p2, w_frac_p2);
      r_idx_p3  <= r_idx_p2;
      r_last_p3 <= r_last_p2;
    end
  end
endmodule

// File: tb/tb_acc_res_normalizer.sv
// Directed and randomized drains of acc_res_normalizer checked against a value-level fp32 model.
module tb_acc_res_normalizer;
  logic         clk = 1'b0;
  logic         rstn;
  logic         drain_valid, drain_ready, clr_valid, clr_ready;
  logic         res_tvalid, res_tready;
  logic [260:0] res_tdata;
  logic         fp_tvalid, fp_tready;
  logic [37:0]  fp_tdata;
  logic         drain_done, idx_err;

  int           total = 0;
  int           bad   = 0;
  int           out_cnt, done_cnt;
  logic         exp_err;
  logic         rand_ready;
  logic [255:0] vals [32];
  logic [37:0]  exp_q [$];
  logic         mon_prev_stall;
  logic [37:0]  mon_prev_data;
  logic [37:0]  mon_exp;

  always #5 clk = ~clk;

  acc_res_normalizer dut (
    .clk         (clk),
    .rstn        (rstn),
    .drain_valid (drain_valid),
    .drain_ready (drain_ready),
    .clr_valid   (clr_valid),
    .clr_ready   (clr_ready),
    .res_tvalid  (res_tvalid),
    .res_tready  (res_tready),
    .res_tdata   (res_tdata),
    .fp_tvalid   (fp_tvalid),
    .fp_tready   (fp_tready),
    .fp_tdata    (fp_tdata),
    .drain_done  (drain_done),
    .idx_err     (idx_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // value = acc / 2^128; fp32 from the position of the top set bit, truncated.
  function automatic logic [31:0] ref_fp(input logic [255:0] a);
    logic         s;
    logic [255:0] m;
    logic [255:0] sh;
    int           p;
    int           e;
    s = a[255];
    m = s ? (256'd0 - a) : a;
    if (m == 256'd0) return {s, 31'd0};
    p = 0;
    for (int b = 0; b < 256; b++) if (m[b]) p = b;
    e = p - 128 + 127;
    if (e <= 0)   return {s, 31'd0};
    if (e >= 255) return {s, 8'hFF, 23'd0};
    sh = (p >= 23) ? (m >> (p - 23)) : (m << (23 - p));
    return {s, 8'(e), sh[22:0]};
  endfunction

  function automatic logic [255:0] rand_acc();
    logic [255:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    r = r >> $urandom_range(0, 255);
    if ($urandom_range(0, 1) == 1) r = 256'd0 - r;
    return r;
  endfunction

  task automatic reset_checks(input string pfx);
    chk({pfx, "_drain_ready"}, drain_ready, 1);
    chk({pfx, "_clr_valid"},   clr_valid,   0);
    chk({pfx, "_res_tready"},  res_tready,  0);
    chk({pfx, "_fp_tvalid"},   fp_tvalid,   0);
    chk({pfx, "_drain_done"},  drain_done,  0);
    chk({pfx, "_idx_err"},     idx_err,     0);
  endtask

  task automatic run_drain(input int clr_delay, input int reset_at, input int bad_at);
    int         guard;
    logic [4:0] idx;
    out_cnt  = 0;
    done_cnt = 0;
    @(negedge clk);
    chk("idle_drain_ready", drain_ready, 1);
    chk("idx_err_before_accept", idx_err, exp_err);
    clr_ready   = (clr_delay == 0);
    drain_valid = 1'b1;
    @(negedge clk);
    exp_err = 1'b0;
    chk("clr_valid", clr_valid, 1);
    chk("busy_drain_ready", drain_ready, 0);
    chk("idx_err_after_accept", idx_err, 0);
    if (clr_delay == 0) drain_valid = 1'b0;
    if (clr_delay > 0) begin
      res_tvalid = 1'b1;
      res_tdata  = {5'd0, vals[0]};
      for (int k = 0; k < clr_delay; k++) begin
        @(negedge clk);
        chk("clr_hold_valid", clr_valid, 1);
        chk("clr_hold_res_tready", res_tready, 0);
        chk("clr_hold_drain_ready", drain_ready, 0);
      end
      drain_valid = 1'b0;
      clr_ready   = 1'b1;
    end
    for (int i = 0; i < 32; i++) begin
      if (i == reset_at) begin
        res_tvalid = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        reset_checks("midreset");
        exp_q.delete();
        exp_err = 1'b0;
        @(posedge clk);
        #2 rstn = 1'b1;
        return;
      end
      if ($urandom_range(0, 3) == 0) begin
        res_tvalid = 1'b0;
        @(negedge clk);
      end
      idx        = (i == bad_at) ? 5'd9 : 5'(i);
      res_tvalid = 1'b1;
      res_tdata  = {idx, vals[i]};
      guard = 0;
      while (!res_tready && guard < 400) begin
        @(negedge clk);
        guard++;
      end
      if (!res_tready) begin
        chk("res_tready_wait", res_tready, 1);
        res_tvalid = 1'b0;
        return;
      end
      exp_q.push_back({(i == 31), idx, ref_fp(vals[i])});
      if (idx != 5'(i)) exp_err = 1'b1;
      @(negedge clk);
    end
    res_tvalid = 1'b0;
    guard = 0;
    while (!drain_ready && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_end", drain_ready, 1);
    chk("out_count", out_cnt, 32);
    chk("done_count", done_cnt, 1);
    chk("queue_left", exp_q.size(), 0);
    chk("idx_err_end", idx_err, exp_err);
    chk("end_clr_valid", clr_valid, 0);
    chk("end_fp_tvalid", fp_tvalid, 0);
  endtask

  // Output backpressure: changed just after each rising edge.
  initial begin
    fp_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1 fp_tready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Output monitor: ordering, content, stall stability and drain_done.
  initial begin
    mon_prev_stall = 1'b0;
    mon_prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
        mon_prev_stall = 1'b0;
      end else begin
        if (mon_prev_stall) begin
          chk("stall_tvalid", fp_tvalid, 1);
          chk("stall_tdata", fp_tdata, mon_prev_data);
        end
        chk("drain_done_pulse", drain_done, fp_tvalid & fp_tready & fp_tdata[37]);
        if (drain_done) done_cnt++;
        if (fp_tvalid && fp_tready) begin
          out_cnt++;
          if (exp_q.size() == 0) begin
            total++;
            assert (exp_q.size() != 0) else begin
              bad++;
              $error("FAIL out_unexpected observed=%h expected=none", fp_tdata);
            end
          end else begin
            mon_exp = exp_q.pop_front();
            chk("out_beat", fp_tdata, mon_exp);
          end
        end
        mon_prev_stall = fp_tvalid & ~fp_tready;
        mon_prev_data  = fp_tdata;
      end
    end
  end

  initial begin
    logic [255:0] t;
    rstn        = 1'b0;
    drain_valid = 1'b0;
    clr_ready   = 1'b1;
    res_tvalid  = 1'b0;
    res_tdata   = '0;
    rand_ready  = 1'b0;
    exp_err     = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks("reset");
    @(posedge clk);
    #2 rstn = 1'b1;

    // 1.0 on every entry
    for (int i = 0; i < 32; i++) vals[i] = 256'd1 << 128;
    run_drain(0, -1, -1);

    // signed / zero / extreme / denormal-boundary values, rest random
    for (int i = 0; i < 32; i++) vals[i] = rand_acc();
    t       = 256'd3 << 127;
    vals[0] = 256'd0 - t;
    vals[1] = 256'd0;
    vals[2] = 256'd1 << 255;
    vals[3] = 256'd1;
    vals[4] = 256'd1 << 2;
    vals[5] = 256'd1 << 1;
    run_drain(0, -1, -1);

    // random output backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 32; i++) vals[i] = rand_acc();
    run_drain(0, -1, -1);
    rand_ready = 1'b0;

    // accumulator slow to accept the clear
    for (int i = 0; i < 32; i++) vals[i] = rand_acc();
    run_drain(10, -1, -1);

    // reset mid-drain, then a full drain with a wrong index on beat 7
    rand_ready = 1'b1;
    for (int i = 0; i < 32; i++) vals[i] = rand_acc();
    run_drain(0, 12, -1);
    for (int i = 0; i < 32; i++) vals[i] = rand_acc();
    run_drain(0, -1, 7);
    rand_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("idx_err_sticky", idx_err, 1);
    for (int i = 0; i < 32; i++) vals[i] = rand_acc();
    run_drain(0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
